mem_responder: RTL and testbench

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/cpu_types_pkg.sv | 15 +
 rtl/mem_responder_if.sv | 39 +++
 rtl/mem_responder.sv | 153 +++++++++++++++
 tb/tb_mem_responder.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU-side types used by the memory responder and its neighbours.
//   word_t      : 32-bit data/address word
//   ramstate_t  : status reported by the RAM each cycle
package cpu_types_pkg;

   typedef logic [31:0] word_t;

   typedef enum logic [1:0] {
      FREE   = 2'd0,
      BUSY   = 2'd1,
      ACCESS = 2'd2,
      ERROR  = 2'd3
   } ramstate_t;

endpackage

// File: rtl/mem_responder_if.sv
// Bus bundle between the caches, the memory responder and the RAM.
//   icache side : iREN, iaddr -> responder ; iwait, iload <- responder
//   dcache side : dREN, dWEN, daddr, dstore -> responder ; dwait, dload <- responder
//   RAM side    : ramREN, ramWEN, ramaddr, ramstore <- responder ; ramload, ramstate -> responder
// slave  : the responder's view.
// master : the environment's view (caches plus RAM).
interface mem_responder_if;
   import cpu_types_pkg::*;

   logic      iREN;
   word_t     iaddr;
   logic      iwait;
   word_t     iload;

   logic      dREN;
   logic      dWEN;
   word_t     daddr;
   word_t     dstore;
   logic      dwait;
   word_t     dload;

   logic      ramREN;
   logic      ramWEN;
   word_t     ramaddr;
   word_t     ramstore;
   word_t     ramload;
   ramstate_t ramstate;

   modport slave (
      input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
      output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
   );

   modport master (
      output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
      input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
   );

endinterface

// File: rtl/mem_responder.sv
// Memory responder: arbitrates instruction and data requests onto a single
// RAM port, retries RAM errors up to RETRY_MAX times, and returns one
// wait=0 cycle per completed transaction.
//   CLK  : clock, rising edge
//   nRST : asynchronous reset, active high
//   bus  : cache and RAM signals (mem_responder_if.slave)
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | no owner; RAM enables low; grant decided this cycle
// IFETCH | serving icache read, ramREN high
// DREAD  | serving dcache read, ramREN high
// DWRITE | serving dcache write, ramWEN high
// RETRY  | one dead cycle after a RAM ERROR, then back to the op in op_q
module mem_responder
   import cpu_types_pkg::*;
#(
   parameter int unsigned RETRY_MAX = 4
) (
   input  logic           CLK,
   input  logic           nRST,
   mem_responder_if.slave bus
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      IFETCH = 3'd1,
      DREAD  = 3'd2,
      DWRITE = 3'd3,
      RETRY  = 3'd4
   } state_t;

   localparam word_t ERR_WORD = 32'hBAD1BAD1;
   localparam int    CW       = (RETRY_MAX < 1) ? 1 : $clog2(RETRY_MAX + 1);
   localparam logic [CW-1:0] RETRY_LIM = CW'(RETRY_MAX);

   state_t        state_q, state_d;
   state_t        op_q, op_d;
   word_t         addr_q, addr_d;
   word_t         store_q, store_d;
   logic [CW-1:0] retry_q, retry_d;
   logic          last_data_q, last_data_d;

   state_t grant;
   logic   owner_req;
   logic   done;
   word_t  resp;
   logic   iwait_c, dwait_c;
   word_t  iload_c, dload_c;

   always_comb begin
      state_d     = state_q;
      op_d        = op_q;
      addr_d      = addr_q;
      store_d     = store_q;
      retry_d     = retry_q;
      last_data_d = last_data_q;
      grant       = IDLE;
      owner_req   = 1'b0;
      done        = 1'b0;
      resp        = '0;
      iwait_c     = 1'b1;
      dwait_c     = 1'b1;
      iload_c     = '0;
      dload_c     = '0;

      case (state_q)
         IDLE: begin
            // After a data completion a waiting ifetch jumps the queue so
            // the icache cannot be starved by back-to-back data traffic.
            if (last_data_q && bus.iREN)  grant = IFETCH;
            else if (bus.dWEN)            grant = DWRITE;
            else if (bus.dREN)            grant = DREAD;
            else if (bus.iREN)            grant = IFETCH;

            if (grant != IDLE) begin
               state_d = grant;
               op_d    = grant;
               retry_d = '0;
               addr_d  = (grant == IFETCH) ? bus.iaddr : bus.daddr;
               store_d = (grant == DWRITE) ? bus.dstore : '0;
            end
         end

         IFETCH, DREAD, DWRITE: begin
            if (state_q == IFETCH)     owner_req = bus.iREN;
            else if (state_q == DREAD) owner_req = bus.dREN;
            else                       owner_req = bus.dWEN;

            if (!owner_req) begin
               // Requester gave up: leave quietly, no wait pulse.
               state_d = IDLE;
            end else if (retry_q == RETRY_LIM) begin
               done = 1'b1;
               resp = ERR_WORD;
            end else if (bus.ramstate == ACCESS) begin
               done = 1'b1;
               resp = (state_q == DWRITE) ? word_t'('0) : bus.ramload;
            end else if (bus.ramstate == ERROR) begin
               state_d = RETRY;
               retry_d = retry_q + CW'(1);
            end

            if (done) begin
               state_d     = IDLE;
               last_data_d = (state_q != IFETCH);
               if (state_q == IFETCH) begin
                  iwait_c = 1'b0;
                  iload_c = resp;
               end else begin
                  dwait_c = 1'b0;
                  dload_c = resp;
               end
            end
         end

         RETRY:   state_d = op_q;

         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK or posedge nRST) begin
      if (nRST) begin
         state_q     <= IDLE;
         op_q        <= IDLE;
         addr_q      <= '0;
         store_q     <= '0;
         retry_q     <= '0;
         last_data_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         op_q        <= op_d;
         addr_q      <= addr_d;
         store_q     <= store_d;
         retry_q     <= retry_d;
         last_data_q <= last_data_d;
      end
   end

   // Enables decode straight from the state register, so an async reset
   // drops them at once.
   assign bus.ramREN   = (state_q == IFETCH) || (state_q == DREAD);
   assign bus.ramWEN   = (state_q == DWRITE);
   assign bus.ramaddr  = addr_q;
   assign bus.ramstore = store_q;

   assign bus.iwait = iwait_c;
   assign bus.dwait = dwait_c;
   assign bus.iload = iload_c;
   assign bus.dload = dload_c;

endmodule

// File: tb/tb_mem_responder.sv
module tb_mem_responder;
   import cpu_types_pkg::*;

   logic CLK;
   logic nRST;

   mem_responder_if bus ();

   mem_responder #(.RETRY_MAX(4)) dut (
      .CLK  (CLK),
      .nRST (nRST),
      .bus  (bus.slave)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   int    checks = 0;
   int    errors = 0;
   word_t iexp[$];
   word_t dexp[$];

   // Scoreboard: pops an expected load whenever a wait=0 cycle appears.
   always @(negedge CLK) begin
      if (!nRST) begin
         checks++;
         if (bus.iwait === 1'b0) begin
            if (iexp.size() == 0) begin
               errors++;
               $display("FAIL ipulse_unexpected iload=%h expected no pulse", bus.iload);
            end else begin
               word_t e;
               e = iexp.pop_front();
               if (bus.iload !== e) begin
                  errors++;
                  $display("FAIL iload got=%h exp=%h", bus.iload, e);
               end
            end
         end else if (bus.iload !== 32'h0) begin
            errors++;
            $display("FAIL iload_idle got=%h exp=0", bus.iload);
         end

         checks++;
         if (bus.dwait === 1'b0) begin
            if (dexp.size() == 0) begin
               errors++;
               $display("FAIL dpulse_unexpected dload=%h expected no pulse", bus.dload);
            end else begin
               word_t e;
               e = dexp.pop_front();
               if (bus.dload !== e) begin
                  errors++;
                  $display("FAIL dload got=%h exp=%h", bus.dload, e);
               end
            end
         end else if (bus.dload !== 32'h0) begin
            errors++;
            $display("FAIL dload_idle got=%h exp=0", bus.dload);
         end

         checks++;
         if ((bus.ramREN & bus.ramWEN) !== 1'b0) begin
            errors++;
            $display("FAIL ram_enables ren=%b wen=%b exp not both 1", bus.ramREN, bus.ramWEN);
         end
      end
   end

   task automatic cyc();
      @(posedge CLK);
      #1;
   endtask

   task automatic test_queues_empty(input string name);
      checks++;
      if (iexp.size() != 0 || dexp.size() != 0) begin
         errors++;
         $display("FAIL %s_missing_pulse iq=%0d dq=%0d exp 0 0", name, iexp.size(), dexp.size());
         iexp.delete();
         dexp.delete();
      end
   endtask

   task automatic test_reset();
      nRST = 1'b1;
      repeat (2) @(negedge CLK);
      checks++;
      if (bus.iwait !== 1'b1 || bus.dwait !== 1'b1) begin
         errors++;
         $display("FAIL reset_wait iwait=%b dwait=%b exp 1 1", bus.iwait, bus.dwait);
      end
      checks++;
      if (bus.ramREN !== 1'b0 || bus.ramWEN !== 1'b0) begin
         errors++;
         $display("FAIL reset_enables ren=%b wen=%b exp 0 0", bus.ramREN, bus.ramWEN);
      end
      checks++;
      if (bus.ramaddr !== 32'h0 || bus.ramstore !== 32'h0) begin
         errors++;
         $display("FAIL reset_addr ramaddr=%h ramstore=%h exp 0 0", bus.ramaddr, bus.ramstore);
      end
      cyc();
      nRST = 1'b0;
   endtask

   task automatic test_ifetch();
      cyc();
      bus.iREN = 1'b1; bus.iaddr = 32'h40; bus.ramstate = BUSY;
      iexp.push_back(32'h2401000A);
      cyc();
      @(negedge CLK);
      checks++;
      if (bus.ramREN !== 1'b1 || bus.ramaddr !== 32'h40) begin
         errors++;
         $display("FAIL ifetch_cmd ren=%b addr=%h exp 1 00000040", bus.ramREN, bus.ramaddr);
      end
      bus.iaddr = 32'h80;
      cyc();
      cyc();
      bus.ramstate = ACCESS; bus.ramload = 32'h2401000A;
      @(negedge CLK);
      checks++;
      if (bus.ramaddr !== 32'h40) begin
         errors++;
         $display("FAIL ifetch_addr_held addr=%h exp 00000040", bus.ramaddr);
      end
      cyc();
      bus.iREN = 1'b0; bus.ramstate = FREE; bus.ramload = 32'h0;
      @(negedge CLK);
      test_queues_empty("ifetch");
   endtask

   task automatic test_contention();
      cyc();
      bus.iREN = 1'b1; bus.iaddr = 32'h44;
      bus.dREN = 1'b1; bus.daddr = 32'h200;
      bus.ramstate = ACCESS; bus.ramload = 32'h11110200;
      dexp.push_back(32'h11110200);
      cyc();
      @(negedge CLK);
      checks++;
      if (bus.ramaddr !== 32'h200 || bus.ramREN !== 1'b1) begin
         errors++;
         $display("FAIL contention_dread_first addr=%h ren=%b exp 00000200 1", bus.ramaddr, bus.ramREN);
      end
      cyc();
      bus.dREN = 1'b0; bus.dWEN = 1'b1; bus.daddr = 32'h300; bus.dstore = 32'h5;
      bus.ramload = 32'h22220044;
      iexp.push_back(32'h22220044);
      cyc();
      @(negedge CLK);
      checks++;
      if (bus.ramaddr !== 32'h44 || bus.ramREN !== 1'b1 || bus.ramWEN !== 1'b0) begin
         errors++;
         $display("FAIL contention_ifetch_next addr=%h ren=%b wen=%b exp 00000044 1 0",
                  bus.ramaddr, bus.ramREN, bus.ramWEN);
      end
      cyc();
      bus.iREN = 1'b0; bus.ramload = 32'h33333333;
      dexp.push_back(32'h0);
      cyc();
      @(negedge CLK);
      checks++;
      if (bus.ramWEN !== 1'b1 || bus.ramaddr !== 32'h300 || bus.ramstore !== 32'h5) begin
         errors++;
         $display("FAIL contention_write wen=%b addr=%h store=%h exp 1 00000300 00000005",
                  bus.ramWEN, bus.ramaddr, bus.ramstore);
      end
      cyc();
      bus.dWEN = 1'b0; bus.ramstate = FREE; bus.ramload = 32'h0;
      @(negedge CLK);
      test_queues_empty("contention");
   endtask

   task automatic test_write();
      cyc();
      bus.dWEN = 1'b1; bus.daddr = 32'h100; bus.dstore = 32'hDEADBEEF; bus.ramstate = BUSY;
      dexp.push_back(32'h0);
      cyc();
      @(negedge CLK);
      checks++;
      if (bus.ramWEN !== 1'b1 || bus.ramREN !== 1'b0 ||
          bus.ramstore !== 32'hDEADBEEF || bus.ramaddr !== 32'h100) begin
         errors++;
         $display("FAIL write_cmd wen=%b ren=%b store=%h addr=%h exp 1 0 deadbeef 00000100",
                  bus.ramWEN, bus.ramREN, bus.ramstore, bus.ramaddr);
      end
      cyc();
      bus.ramstate = ACCESS;
      cyc();
      bus.dWEN = 1'b0; bus.ramstate = FREE;
      @(negedge CLK);
      checks++;
      if (bus.dwait !== 1'b1 || bus.ramWEN !== 1'b0) begin
         errors++;
         $display("FAIL write_after dwait=%b wen=%b exp 1 0", bus.dwait, bus.ramWEN);
      end
      test_queues_empty("write");
   endtask

   task automatic test_error();
      int retry_cycles;
      retry_cycles = 0;
      cyc();
      bus.iREN = 1'b1; bus.iaddr = 32'h80; bus.ramstate = ERROR;
      iexp.push_back(32'hBAD1BAD1);
      for (int k = 0; k < 4; k++) begin
         cyc();
         @(negedge CLK);
         checks++;
         if (bus.ramREN !== 1'b1 || bus.iwait !== 1'b1) begin
            errors++;
            $display("FAIL error_ifetch_%0d ren=%b iwait=%b exp 1 1", k, bus.ramREN, bus.iwait);
         end
         cyc();
         @(negedge CLK);
         checks++;
         if (bus.ramREN !== 1'b0 || bus.ramWEN !== 1'b0) begin
            errors++;
            $display("FAIL error_retry_%0d ren=%b wen=%b exp 0 0", k, bus.ramREN, bus.ramWEN);
         end else begin
            retry_cycles++;
         end
      end
      cyc();
      @(negedge CLK);
      checks++;
      if (bus.iwait !== 1'b0) begin
         errors++;
         $display("FAIL error_give_up iwait=%b exp 0 after %0d retries", bus.iwait, retry_cycles);
      end
      cyc();
      bus.iREN = 1'b0; bus.ramstate = FREE;
      @(negedge CLK);
      test_queues_empty("error");
   endtask

   task automatic test_abort();
      cyc();
      bus.dREN = 1'b1; bus.daddr = 32'h180; bus.ramstate = BUSY;
      cyc();
      @(negedge CLK);
      checks++;
      if (bus.ramREN !== 1'b1) begin
         errors++;
         $display("FAIL abort_start ren=%b exp 1", bus.ramREN);
      end
      cyc();
      bus.dREN = 1'b0;
      cyc();
      @(negedge CLK);
      checks++;
      if (bus.ramREN !== 1'b0 || bus.dwait !== 1'b1) begin
         errors++;
         $display("FAIL abort_idle ren=%b dwait=%b exp 0 1", bus.ramREN, bus.dwait);
      end
      bus.ramstate = FREE;
      test_queues_empty("abort");
   endtask

   task automatic test_reset_mid();
      cyc();
      bus.iREN = 1'b1; bus.iaddr = 32'h90; bus.ramstate = BUSY;
      cyc();
      #2;
      nRST = 1'b1;
      #1;
      checks++;
      if (bus.ramREN !== 1'b0 || bus.iwait !== 1'b1 || bus.ramaddr !== 32'h0) begin
         errors++;
         $display("FAIL reset_mid ren=%b iwait=%b addr=%h exp 0 1 00000000",
                  bus.ramREN, bus.iwait, bus.ramaddr);
      end
      bus.iREN = 1'b0; bus.ramstate = ACCESS;
      cyc();
      cyc();
      nRST = 1'b0;
      bus.ramstate = FREE;
      cyc();
      @(negedge CLK);
      checks++;
      if (bus.ramREN !== 1'b0 || bus.iwait !== 1'b1) begin
         errors++;
         $display("FAIL reset_mid_after ren=%b iwait=%b exp 0 1", bus.ramREN, bus.iwait);
      end
      test_queues_empty("reset_mid");
   endtask

   initial begin
      nRST         = 1'b1;
      bus.iREN     = 1'b0;
      bus.iaddr    = '0;
      bus.dREN     = 1'b0;
      bus.dWEN     = 1'b0;
      bus.daddr    = '0;
      bus.dstore   = '0;
      bus.ramload  = '0;
      bus.ramstate = FREE;

      test_reset();
      test_ifetch();
      test_contention();
      test_write();
      test_error();
      test_abort();
      test_reset_mid();

      repeat (2) cyc();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout sim_time=%0t exp finish before 100000", $time);
      $fatal(1);
   end

endmodule
